// File: rtl/pe_array_seq_if.sv
// Handshake and configuration bundle between the PE array sequencer, its host
// (job start, preload stream, result acceptance) and the PE array itself.
interface pe_array_seq_if #(
    parameter int K_W = 8
);
    logic           start;
    logic [1:0]     datatype;
    logic           mixed;
    logic [K_W-1:0] k_len;
    logic           c_valid;
    logic [31:0]    c_data;
    logic           c_ready;
    logic           we;
    logic [31:0]    c_out;
    logic           en_inject;
    logic           cm_inject;
    logic [1:0]     datatype_q;
    logic           mixed_q;
    logic           wben;
    logic           out_ready;
    logic           sum_ready;
    logic           busy;
    logic           done;

    modport slave (
        input  start, datatype, mixed, k_len, c_valid, c_data, sum_ready,
        output c_ready, we, c_out, en_inject, cm_inject, datatype_q, mixed_q,
               wben, out_ready, busy, done
    );

    modport master (
        output start, datatype, mixed, k_len, c_valid, c_data, sum_ready,
        input  c_ready, we, c_out, en_inject, cm_inject, datatype_q, mixed_q,
               wben, out_ready, busy, done
    );
endinterface

// File: rtl/pe_array_seq.sv
// Job sequencer for an N x N PE array: accumulator preload, compute enables,
// pipeline drain, optional INT4 compute-mode pass, then result writeback.
module pe_array_seq #(
    parameter int N   = 4,
    parameter int K_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    pe_array_seq_if.slave bus
);
    localparam int MIN_W = $clog2(2 * N + 2);
    localparam int CW    = (K_W > MIN_W) ? K_W : MIN_W;

    // Terminal counts; each phase counts 0..LAST and leaves on LAST.
    localparam logic [CW-1:0] LOAD_LAST      = CW'(N - 1);
    localparam logic [CW-1:0] WB_LAST        = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_FP_LAST  = CW'(2 * N - 1);
    localparam logic [CW-1:0] DRAIN_INT_LAST = CW'(2 * N - 2);
    localparam logic [CW-1:0] CMDRAIN_LAST   = CW'(2 * N - 2);

    localparam logic [1:0] DT_INT4 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_CMODE,
        S_CMDRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [1:0]     datatype_q;
    logic           mixed_q;
    logic [K_W-1:0] k_len_q;
    logic [CW-1:0]  k_last;
    logic [CW-1:0]  drain_last;

    logic           c_ready;
    logic           we;
    logic [31:0]    c_out;
    logic           en_inject;
    logic           cm_inject;
    logic           wben;
    logic           out_ready;
    logic           done;

    assign k_last     = CW'(k_len_q) - CW'(1);
    // INT8 and INT4 share the shorter one-cycle PE latency.
    assign drain_last = datatype_q[1] ? DRAIN_INT_LAST : DRAIN_FP_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Job configuration is captured only on an accepted start and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            datatype_q <= '0;
            mixed_q    <= 1'b0;
            k_len_q    <= '0;
        end else if (state == S_IDLE && bus.start) begin
            datatype_q <= bus.datatype;
            mixed_q    <= bus.mixed;
            k_len_q    <= bus.k_len;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        c_ready   = 1'b0;
        we        = 1'b0;
        c_out     = '0;
        en_inject = 1'b0;
        cm_inject = 1'b0;
        wben      = 1'b0;
        out_ready = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (bus.start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                c_ready = 1'b1;
                if (bus.c_valid) begin
                    we    = 1'b1;
                    c_out = bus.c_data;
                    if (cnt == LOAD_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (k_len_q == '0) ? S_WB : S_COMPUTE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                en_inject = 1'b1;
                if (cnt == k_last) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DRAIN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == drain_last) begin
                    cnt_nxt   = '0;
                    state_nxt = (datatype_q == DT_INT4) ? S_CMODE : S_WB;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CMODE: begin
                cm_inject = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_CMDRAIN;
            end
            S_CMDRAIN: begin
                if (cnt == CMDRAIN_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WB;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WB: begin
                wben      = 1'b1;
                out_ready = bus.sum_ready;
                if (bus.sum_ready) begin
                    if (cnt == WB_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.c_ready    = c_ready;
    assign bus.we         = we;
    assign bus.c_out      = c_out;
    assign bus.en_inject  = en_inject;
    assign bus.cm_inject  = cm_inject;
    assign bus.datatype_q = datatype_q;
    assign bus.mixed_q    = mixed_q;
    assign bus.wben       = wben;
    assign bus.out_ready  = out_ready;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done;
endmodule

// File: doc/pe_array_seq.md
PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Parameters
REQ-001 SHALL have parameter N, default 4, meaning PE array dimension (N x N) and accumulator words per PE.
REQ-002 SHALL have parameter K_W, default 8, meaning width of the compute-length field.

Interface
REQ-003 SHALL have: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have: start  in  1  one-cycle job request, sampled only in IDLE.
REQ-006 SHALL have: datatype  in  2  job type: 0=FP32, 1=FP16, 2=INT8, 3=INT4.
REQ-007 SHALL have: mixed  in  1  FP16 mixed-precision flag.
REQ-008 SHALL have: k_len  in  K_W  number of compute beats.
REQ-009 SHALL have: c_valid, c_data  in  1, 32  accumulator preload stream.
REQ-010 SHALL have: c_ready  out  1  preload accept.
REQ-011 SHALL have: we, c_out  out  1, 32  preload write strobe and data to the array.
REQ-012 SHALL have: en_inject, cm_inject  out  1, 1  enable and compute-mode tokens into PE[0][0] (enleft/enup, cmleft/cmup).
REQ-013 SHALL have: datatype_q, mixed_q  out  2, 1  latched job configuration broadcast to all PEs.
REQ-014 SHALL have: wben, out_ready  out  1, 1  writeback enable and per-beat advance to the array.
REQ-015 SHALL have: sum_ready  in  1  downstream accepts a result word.
REQ-016 SHALL have: busy, done  out  1, 1  job in progress; one-cycle completion pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, COMPUTE, DRAIN, CMODE, CMDRAIN, WB and DONE.
REQ-018 In IDLE with start=1, SHALL latch datatype, mixed and k_len, and enter LOAD next cycle; start SHALL be ignored in all other states.
REQ-019 In LOAD, SHALL drive c_ready=1, and on each c_valid&c_ready SHALL drive we=1 with c_out=c_data in the same cycle.
REQ-020 In LOAD, SHALL count accepted words 0..N-1, and after the Nth word SHALL go to COMPUTE, or directly to WB if k_len_q=0.
REQ-021 In COMPUTE, SHALL hold en_inject=1 for exactly k_len_q consecutive cycles, then go to DRAIN.
REQ-022 In DRAIN, SHALL wait D=2N-2+L cycles, where L=2 for FP32/FP16 and L=1 for INT8/INT4 (N=4: FP D=8, INT D=7).
REQ-023 After DRAIN, SHALL go to CMODE if datatype_q=INT4, else to WB.
REQ-024 In CMODE, SHALL drive cm_inject=1 for 1 cycle, then go to CMDRAIN.
REQ-025 In CMDRAIN, SHALL wait 2N-1 cycles, then go to WB.
REQ-026 In WB, SHALL hold wben=1 and drive out_ready=sum_ready.
REQ-027 In WB, SHALL count beats with sum_ready=1, and after N such beats SHALL go to DONE; sum_ready=0 stalls with no count change.
REQ-028 In DONE, SHALL drive done=1 for exactly one cycle, then return to IDLE; the next start SHALL be accepted no earlier than that IDLE cycle.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 we, en_inject, cm_inject, wben and out_ready SHALL be 0 outside their own states and SHALL never be asserted together.
REQ-031 All cycle counters SHALL be sized for max(k_len, 2N+1, N) without wrap-around.
REQ-032 k_len_q=2^K_W-1 SHALL produce exactly that many en_inject cycles.
REQ-033 datatype_q and mixed_q SHALL remain stable from LOAD through DONE.

Reset
REQ-034 While rst=0, and asynchronously including mid-job, SHALL force state=IDLE and clear all counters.
REQ-035 While rst=0, SHALL hold busy, done, c_ready, we, en_inject, cm_inject, wben and out_ready at 0.
REQ-036 While rst=0, SHALL hold datatype_q=0, mixed_q=0 and c_out=0.
REQ-037 After rst rises, SHALL idle until start is sampled high.

Verification
REQ-038 Bench SHALL cover FP32 with N=4, k_len=3, c_valid held high: 4 we cycles; 3 en_inject cycles; 8 drain cycles; 4 wben beats; done 1 cycle; total 21 cycles from start to done.
REQ-039 Bench SHALL cover INT4 with k_len=2: after 7 drain cycles, cm_inject pulses once, 7 further cycles elapse, then WB runs.
REQ-040 Bench SHALL cover LOAD backpressure and WB stall: c_valid toggling 1,0,1,0 yields exactly 4 we pulses aligned to c_valid; sum_ready low for 5 WB cycles keeps out_ready=0 and the beat count frozen.
REQ-041 Bench SHALL cover start=1 while busy and k_len=0: the busy start is ignored with no second job; k_len=0 goes LOAD->WB with no en_inject asserted.
REQ-042 Bench SHALL cover rst=0 asserted mid-COMPUTE: next sample shows all outputs 0 and state IDLE; a new job after rst=1 completes normally.
